// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer.
//   mux_mode_e            : selection mode (external select or round-robin)
//   MAX_N                 : largest channel count the select helper accepts
//   onehot_and_or_select  : one output bit of a one-hot AND-OR mux
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MAX_N = 64;

    // One column of the data mux: bit b of every channel in 'bits', the
    // grant in 'onehot'. Masking before the OR keeps X on a non-granted
    // channel from leaking into the result.
    function automatic logic onehot_and_or_select(
        input logic [MAX_N-1:0] onehot,
        input logic [MAX_N-1:0] bits
    );
        return |(onehot & bits);
    endfunction

endpackage

// File: rtl/stream_mux_n_1_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : per-channel request
//   ptr          : highest-priority channel this cycle
//   grant_onehot : one-hot grant (all zero when no request)
//   grant_idx    : index of the granted channel
//   grant_valid  : some channel was granted
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant_onehot,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk offsets from the far end back to ptr so the closest requester
    // (smallest offset from ptr) is the last to overwrite the result.
    always_comb begin
        int               j;
        logic [SEL_W-1:0] idx;
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = SEL_W'(j);
            if (req[idx]) begin
                grant_onehot      = '0;
                grant_onehot[idx] = 1'b1;
                grant_idx         = idx;
                grant_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n_1.sv
// N-input valid/ready stream multiplexer with one registered output slot.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : per-channel valid
//   in_data    : per-channel data, packed [N_IN-1:0][WIDTH-1:0]
//   in_ready   : per-channel ready, at most one bit set
//   sel        : channel index (MODE_SEL only)
//   out_valid  : output slot occupied
//   out_data   : registered word
//   out_src    : channel the registered word came from
//   out_ready  : consumer ready
module stream_mux_n_1
    import stream_mux_pkg::*;
#(
    parameter  int        N_IN  = 4,
    parameter  int        WIDTH = 4,
    parameter  mux_mode_e MODE  = MODE_SEL,
    localparam int        SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN-1:0]             in_valid,
    input  logic [N_IN-1:0][WIDTH-1:0]  in_data,
    output logic [N_IN-1:0]             in_ready,
    input  logic [SEL_W-1:0]            sel,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_src,
    input  logic                        out_ready
);

    logic [N_IN-1:0]  sel_onehot;
    logic             sel_gvalid;
    logic [N_IN-1:0]  rr_onehot;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_gvalid;

    logic [N_IN-1:0]  grant_onehot;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_word;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_src_q,   out_src_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    // Select decode: an out-of-range sel matches no channel, so it grants nothing.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(sel) == i) begin
                sel_onehot[i] = in_valid[i];
            end
        end
        sel_gvalid = |sel_onehot;
    end

    rr_arbiter #(.N(N_IN)) u_rr_arbiter (
        .req          (in_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .grant_valid  (rr_gvalid)
    );

    assign grant_onehot = (MODE == MODE_RR) ? rr_onehot : sel_onehot;
    assign grant_idx    = (MODE == MODE_RR) ? rr_idx    : sel;
    assign grant_valid  = (MODE == MODE_RR) ? rr_gvalid : sel_gvalid;

    // The slot can take a word when empty or when it drains this same cycle.
    assign can_load = ~out_valid_q | out_ready;
    assign in_ready = grant_onehot & {N_IN{can_load}};
    assign xfer     = grant_valid & can_load;

    // AND-OR data select, one column (output bit) at a time.
    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_col
            logic [N_IN-1:0] col;
            for (gj = 0; gj < N_IN; gj++) begin : g_ch
                assign col[gj] = in_data[gj][gi];
            end
            assign sel_word[gi] = onehot_and_or_select(MAX_N'(grant_onehot), MAX_N'(col));
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
            out_src_d   = grant_idx;
            rr_ptr_d    = (int'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);
        end else if (out_ready) begin
            // Consumer took the word and nothing refills: empty the slot,
            // leave data/src as they were.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
